// File: rtl/case_6_sdiv_seq_6s_5s_6.sv
// Sequential signed divider: radix-2 restoring division on magnitudes, one quotient bit per cycle, C-style sign fix-up.
// Optional CASE_6_SDIV_DIV0_FLAG_EN adds a registered div0 output flagging a zero divisor.
module case_6_sdiv_seq_6s_5s_6 #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 6,
  parameter int din1_WIDTH = 5,
  parameter int dout_WIDTH = 6
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         ce,
  input  logic                         start,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  output logic                         ready,
  output logic                         done,
  output logic signed [dout_WIDTH-1:0] dout,
`ifdef CASE_6_SDIV_DIV0_FLAG_EN
  output logic signed [din1_WIDTH-1:0] rem,
  output logic                         div0
`else
  output logic signed [din1_WIDTH-1:0] rem
`endif
);

  localparam int MW = din0_WIDTH + 1;
  localparam int CW = $clog2(din0_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t                  state, state_nxt;
  logic [din0_WIDTH-1:0]   quo;   // dividend bits shift out the top, quotient bits enter at the bottom
  logic [MW-1:0]           prem;
  logic [MW-1:0]           dvsr;
  logic [CW-1:0]           cnt;
  logic                    sgn0, sgn1, zdiv;

  logic [din0_WIDTH-1:0]   mag0;
  logic [MW-1:0]           mag1;
  logic [MW-1:0]           shifted, diff;
  logic                    ge;

  // Unsigned magnitude; the most negative dividend maps onto its exact unsigned value.
  function automatic logic [din0_WIDTH-1:0] abs0(input logic [din0_WIDTH-1:0] v);
    return v[din0_WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [MW-1:0] abs1(input logic [din1_WIDTH-1:0] v);
    logic [MW-1:0] ext;
    ext = {{(MW-din1_WIDTH){v[din1_WIDTH-1]}}, v};
    return ext[MW-1] ? (~ext + 1'b1) : ext;
  endfunction

  function automatic logic [dout_WIDTH-1:0] fix_quo(input logic [din0_WIDTH-1:0] q,
                                                    input logic neg, input logic z);
    if (z) return '1;
    return dout_WIDTH'(neg ? (~q + 1'b1) : q);
  endfunction

  // Remainder follows the dividend sign; a zero divisor leaves |din0| here, giving din0 back.
  function automatic logic [din1_WIDTH-1:0] fix_rem(input logic [MW-1:0] r, input logic neg);
    return din1_WIDTH'(neg ? (~r + 1'b1) : r);
  endfunction

  always_comb begin
    mag0    = abs0(din0);
    mag1    = abs1(din1);
    shifted = {prem[MW-2:0], quo[din0_WIDTH-1]};
    ge      = (shifted >= dvsr);
    diff    = shifted - dvsr;
  end

  always_comb begin
    state_nxt = state;
    ready     = (state == IDLE);
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
      quo   <= '0;
      prem  <= '0;
      dvsr  <= '0;
      cnt   <= '0;
      sgn0  <= 1'b0;
      sgn1  <= 1'b0;
      zdiv  <= 1'b0;
      done  <= 1'b0;
      dout  <= '0;
      rem   <= '0;
`ifdef CASE_6_SDIV_DIV0_FLAG_EN
      div0  <= 1'b0;
`endif
    end else if (ce) begin
      state <= state_nxt;
      done  <= (state == FIX);
      case (state)
        IDLE: if (start) begin
          quo  <= mag0;
          prem <= '0;
          dvsr <= mag1;
          cnt  <= CW'(din0_WIDTH);
          sgn0 <= din0[din0_WIDTH-1];
          sgn1 <= din1[din1_WIDTH-1];
          zdiv <= (din1 == '0);
        end
        CALC: begin
          prem <= ge ? diff : shifted;
          quo  <= {quo[din0_WIDTH-2:0], ge};
          cnt  <= cnt - 1'b1;
        end
        FIX: begin
          dout <= fix_quo(quo, sgn0 ^ sgn1, zdiv);
          rem  <= fix_rem(prem, sgn0);
`ifdef CASE_6_SDIV_DIV0_FLAG_EN
          div0 <= zdiv;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_case_6_sdiv_seq_6s_5s_6.sv
// Self-checking bench for case_6_sdiv_seq_6s_5s_6 against a C-semantics division model.
module tb_case_6_sdiv_seq_6s_5s_6;

  localparam int W0 = 6;
  localparam int W1 = 5;

  logic                 ap_clk = 1'b0;
  logic                 ap_rst_n = 1'b1;
  logic                 ce = 1'b1;
  logic                 start = 1'b0;
  logic signed [W0-1:0] din0 = '0;
  logic signed [W1-1:0] din1 = '0;
  logic                 ready, done;
  logic signed [W0-1:0] dout;
  logic signed [W1-1:0] rem;
`ifdef CASE_6_SDIV_DIV0_FLAG_EN
  logic                 div0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 ap_clk = ~ap_clk;

  case_6_sdiv_seq_6s_5s_6 #(.ID(1), .din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(W0)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .start(start),
    .din0(din0), .din1(din1), .ready(ready), .done(done), .dout(dout),
`ifdef CASE_6_SDIV_DIV0_FLAG_EN
    .rem(rem), .div0(div0)
`else
    .rem(rem)
`endif
  );

  // C semantics: truncate toward zero, remainder carries dividend sign.
  function automatic void model(input int a, input int b, output logic [W0-1:0] q, output logic [W1-1:0] r);
    int qi, ri;
    if (b == 0) begin qi = -1; ri = a; end
    else if (a == -(1 << (W0-1)) && b == -1) begin qi = a; ri = 0; end
    else begin qi = a / b; ri = a % b; end
    q = qi[W0-1:0];
    r = ri[W1-1:0];
  endfunction

  // Issue from the current negedge; lat = edge index (start at edge 0) where done first shows, -1 on timeout.
  task automatic issue_wait(input int a, input int b, output int lat);
    din0 = a[W0-1:0]; din1 = b[W1-1:0]; start = 1'b1;
    @(negedge ap_clk); start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge ap_clk);
      if (done) begin lat = c; break; end
    end
  endtask

  task automatic run_op(input int a, input int b, output int lat);
    @(negedge ap_clk);
    issue_wait(a, b, lat);
  endtask

  task automatic test_reset();
    #1 ap_rst_n = 1'b0;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (dout !== 6'd0 || rem !== 5'd0) begin errors++; $display("FAIL reset_out got %h/%h want 0/0", dout, rem); end
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat; int bad_ready;
    @(negedge ap_clk);
    din0 = 6'sd23; din1 = 5'sd5; start = 1'b1;
    @(negedge ap_clk); start = 1'b0;
    lat = -1; bad_ready = 0;
    for (int c = 1; c <= 40; c++) begin
      if (!done && ready !== 1'b0) bad_ready++;
      @(negedge ap_clk);
      if (done) begin lat = c; break; end
    end
    checks++; if (lat != 7) begin errors++; $display("FAIL basic_latency got %0d want 7", lat); end
    checks++; if (bad_ready != 0) begin errors++; $display("FAIL basic_ready_busy got %0d high cycles want 0", bad_ready); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL basic_ready_done got %b want 1", ready); end
    checks++; if (dout !== 6'sd4 || rem !== 5'sd3) begin errors++; $display("FAIL basic_result got %0d/%0d want 4/3", dout, rem); end
    @(negedge ap_clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
  endtask

  task automatic test_sign_and_boundary();
    int ta [8] = '{-23, 23, -23, -32, -32, 31, 9, -32};
    int tb [8] = '{5, -5, -5, -1, 1, -16, 0, 0};
    int lat; logic [W0-1:0] eq; logic [W1-1:0] er;
    for (int i = 0; i < 8; i++) begin
      run_op(ta[i], tb[i], lat);
      model(ta[i], tb[i], eq, er);
      checks++; if (lat != 7) begin errors++; $display("FAIL bnd_latency %0d/%0d got %0d want 7", ta[i], tb[i], lat); end
      checks++; if (dout !== eq || rem !== er) begin errors++; $display("FAIL bnd_result %0d/%0d got %h/%h want %h/%h", ta[i], tb[i], dout, rem, eq, er); end
`ifdef CASE_6_SDIV_DIV0_FLAG_EN
      checks++; if (div0 !== (tb[i] == 0)) begin errors++; $display("FAIL bnd_div0 %0d/%0d got %b want %b", ta[i], tb[i], div0, tb[i] == 0); end
`endif
    end
  endtask

  task automatic test_sweep();
    int lat; logic [W0-1:0] eq; logic [W1-1:0] er;
    for (int a = -32; a < 32; a++) begin
      for (int b = -16; b < 16; b++) begin
        if (b == 0) continue;
        run_op(a, b, lat);
        model(a, b, eq, er);
        checks++; if (lat != 7 || dout !== eq || rem !== er) begin errors++; $display("FAIL sweep %0d/%0d got lat %0d %h/%h want lat 7 %h/%h", a, b, lat, dout, rem, eq, er); end
      end
    end
  endtask

  task automatic test_random();
    int a, b, lat; logic [W0-1:0] eq; logic [W1-1:0] er;
    for (int i = 0; i < 150; i++) begin
      a = int'($urandom_range(63)) - 32;
      b = int'($urandom_range(31)) - 16;
      run_op(a, b, lat);
      model(a, b, eq, er);
      checks++; if (lat != 7 || dout !== eq || rem !== er) begin errors++; $display("FAIL random %0d/%0d got lat %0d %h/%h want lat 7 %h/%h", a, b, lat, dout, rem, eq, er); end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(23, 5, lat);
    checks++; if (lat != 7 || dout !== 6'sd4) begin errors++; $display("FAIL b2b_first got lat %0d q %0d want 7/4", lat, dout); end
    issue_wait(7, 2, lat);
    checks++; if (lat != 7) begin errors++; $display("FAIL b2b_latency got %0d want 7", lat); end
    checks++; if (dout !== 6'sd3 || rem !== 5'sd1) begin errors++; $display("FAIL b2b_result got %0d/%0d want 3/1", dout, rem); end
  endtask

  task automatic test_busy_start();
    int lat, extra;
    @(negedge ap_clk);
    din0 = 6'sd23; din1 = 5'sd5; start = 1'b1;
    @(negedge ap_clk); start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 3) begin din0 = 6'sd7; din1 = 5'sd2; start = 1'b1; end
      if (k == 4) start = 1'b0;
      @(negedge ap_clk);
      if (done) begin lat = k; break; end
    end
    checks++; if (lat != 7 || dout !== 6'sd4 || rem !== 5'sd3) begin errors++; $display("FAIL busy_result got lat %0d %0d/%0d want 7 4/3", lat, dout, rem); end
    extra = 0;
    repeat (12) begin @(negedge ap_clk); if (done) extra++; end
    checks++; if (extra != 0) begin errors++; $display("FAIL busy_ignored got %0d extra done want 0", extra); end
  endtask

  task automatic test_ce_stall();
    int lat, held;
    @(negedge ap_clk);
    din0 = -6'sd23; din1 = 5'sd5; start = 1'b1;
    @(negedge ap_clk); start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 3) ce = 1'b0;
      if (k == 6) ce = 1'b1;
      @(negedge ap_clk);
      if (done) begin lat = k; break; end
    end
    ce = 1'b1;
    checks++; if (lat != 10) begin errors++; $display("FAIL ce_stall_latency got %0d want 10", lat); end
    checks++; if (dout !== -6'sd4 || rem !== -5'sd3) begin errors++; $display("FAIL ce_stall_result got %0d/%0d want -4/-3", dout, rem); end
    run_op(23, -5, lat);
    ce = 1'b0;
    held = 0;
    repeat (3) begin @(negedge ap_clk); if (done) held++; end
    checks++; if (held != 3) begin errors++; $display("FAIL ce_done_hold got %0d of 3 cycles high", held); end
    checks++; if (dout !== -6'sd4 || rem !== 5'sd3) begin errors++; $display("FAIL ce_done_result got %0d/%0d want -4/3", dout, rem); end
    ce = 1'b1;
    @(negedge ap_clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL ce_done_release got %b want 0", done); end
  endtask

  task automatic test_reset_mid();
    int lat, extra;
    @(negedge ap_clk);
    din0 = 6'sd31; din1 = 5'sd3; start = 1'b1;
    @(negedge ap_clk); start = 1'b0;
    @(negedge ap_clk); @(negedge ap_clk);
    ap_rst_n = 1'b0;
    #1;
    checks++; if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl got ready %b done %b want 1/0", ready, done); end
    checks++; if (dout !== 6'd0 || rem !== 5'd0) begin errors++; $display("FAIL rstmid_out got %h/%h want 0/0", dout, rem); end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    extra = 0;
    repeat (12) begin @(negedge ap_clk); if (done) extra++; end
    checks++; if (extra != 0) begin errors++; $display("FAIL rstmid_no_done got %0d want 0", extra); end
    run_op(31, 3, lat);
    checks++; if (lat != 7 || dout !== 6'sd10 || rem !== 5'sd1) begin errors++; $display("FAIL rstmid_after got lat %0d %0d/%0d want 7 10/1", lat, dout, rem); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign_and_boundary();
    test_back_to_back();
    test_busy_start();
    test_ce_stall();
    test_reset_mid();
    test_random();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/case_6_sdiv_seq_6s_5s_6.md
Name: case_6_sdiv_seq_6s_5s_6

Overview:
- Multi-cycle signed integer divider core, the inverse operator of the team's combinational signed multiplier cores.
- Instantiated by generated datapaths wherever a signed "/" or "%" appears.
- Radix-2 restoring division on operand magnitudes, with a sign fix-up step; one quotient bit per cycle.
- start/done handshake, plus a clock enable for pipeline stall.

Parameters:
- ID, 1, instance identifier; no functional effect.
- din0_WIDTH, 6, dividend width (signed).
- din1_WIDTH, 5, divisor width (signed).
- dout_WIDTH, 6, quotient width (signed); must equal din0_WIDTH.

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable; when low, all state and outputs hold.
- start  in  1  request; sampled only when ready=1 and ce=1.
- din0  in  din0_WIDTH  signed dividend.
- din1  in  din1_WIDTH  signed divisor.
- ready  out  1  high in IDLE; core can accept start.
- done  out  1  one-cycle pulse when results are valid.
- dout  out  dout_WIDTH  signed quotient, held until next done.
- rem  out  din1_WIDTH  signed remainder, held until next done.

Behaviour:
- Reset (async assert, sync release): state=IDLE, ready=1, done=0, dout=0, rem=0, internal regs=0. Reset mid-operation aborts the division; no done is issued.
- States and transitions:
  - IDLE: on start, capture |din0|, |din1| and the sign bits; iteration count=din0_WIDTH; go to CALC.
  - CALC: each cycle, shift partial remainder left by one with the next dividend MSB; if partial remainder >= |divisor|, subtract and set quotient bit to 1, else quotient bit=0. Decrement count; leave for FIX when count reaches 0.
  - FIX: apply signs, register dout/rem, pulse done=1, go to IDLE.
- Magnitudes are computed at din0_WIDTH+1 bits so that |-32| is representable.
- Latency: with start sampled at edge 0, done=1 after edge din0_WIDTH+1 (edge 7 at defaults), for din0_WIDTH+1 = 7 cycles busy.
- ready=0 from edge 0 until the edge that asserts done; ready=1 in the same cycle done=1.
- A start in that cycle is accepted, so back-to-back throughput is one result per 7 cycles.
- start while ready=0 is ignored. It is not queued.
- done is high for exactly one ce-enabled cycle. When ce=0 in the done cycle, done stays high until ce returns.
- Arithmetic follows C semantics:
  - Quotient truncates toward zero.
  - Quotient is negative iff the operand signs differ and the quotient is nonzero.
  - Remainder takes the sign of the dividend.
  - Invariant: din0 == dout*din1 + rem, whenever the divisor is nonzero and no overflow occurs.
- Overflow: -2^(din0_WIDTH-1) / -1 wraps: dout=-32 (0x20), rem=0. No error is signalled.
- Divide by zero:
  - Detected in IDLE at capture; CALC still runs the full count, so latency is unchanged.
  - Result: dout=all ones (-1), rem=din0 truncated to din1_WIDTH bits.
- ce=0 freezes the state, count, partial remainder and outputs.
- Operands are captured at start; din0/din1 may change freely afterward.

Optional Feature:
- Macro: CASE_6_SDIV_DIV0_FLAG_EN.
- When defined:
  - Adds output port div0 (out, 1 bit).
  - div0 is registered alongside dout in FIX, set when the captured divisor was 0, and held until the next done.
  - div0 resets to 0.
- When undefined: the port is absent; divide-by-zero results are unchanged.

Test Plan:
- din0=23, din1=5, start pulse, ce=1 -> done at edge 7; dout=4, rem=3; ready low for edges 1..6.
- Sign matrix:
  - -23/5 -> dout=-4, rem=-3.
  - 23/-5 -> dout=-4, rem=3.
  - -23/-5 -> dout=4, rem=-3.
  - Exhaustive sweep of all 64x32 pairs checked against the C model, excluding zero divisor.
- Boundary cases:
  - -32/-1 -> dout=-32, rem=0.
  - -32/1 -> dout=-32, rem=0.
  - 31/-16 -> dout=-1, rem=15.
  - 9/0 -> dout=-1, rem=9, div0=1 when the macro is defined.
- Handshake:
  - start for 7/2 issued in the done cycle of 23/5 -> accepted; second done 7 cycles later with dout=3, rem=1.
  - start asserted while busy -> ignored.
- ce stall: deassert ce for 3 cycles during CALC -> done delayed to edge 10; result unchanged.
  - ce=0 during the done cycle -> done held high until ce returns.
- Reset: assert ap_rst_n=0 at edge 3 of a division -> immediately ready=1, done=0, dout=0, rem=0; no done after release.
  - New start after release completes normally.
